viscapture: RTL and testbench

- Downstream end of the visibility-chain output stream.
- Receives accumulated visibility frames (frame/valid/first/last/real/imag) from a correlator chain and captures each complete frame into one half of a ping-pong buffer.
- Streams completed frames out over a valid/ready handshake toward the readout/host bridge.
- Validates frame structure and drops malformed frames or frames arriving while both buffers are occupied.

---
 rtl/vis_pkg.sv | 27 ++
 rtl/viscapture_if.sv | 24 ++
 rtl/visram_dp.sv | 28 ++
 rtl/viscapture.sv | 274 +++++++++++++++++++++++++++
 tb/tb_viscapture.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vis_pkg.sv
// Shared types and helpers for the visibility capture block.
// Optional header beat is enabled with VISCAPTURE_HEADER_EN.
package vis_pkg;

  typedef logic [1:0] wstate_t;
  typedef logic [1:0] rstate_t;

  localparam wstate_t W_IDLE = 2'd0;
  localparam wstate_t W_FILL = 2'd1;
  localparam wstate_t W_DROP = 2'd2;

  localparam rstate_t R_IDLE   = 2'd0;
  localparam rstate_t R_LOAD   = 2'd1;
  localparam rstate_t R_STREAM = 2'd2;

  localparam int HDR_SEQ_W   = 16;
  localparam int HDR_SEQ_LSB = 0;

  function automatic int dbits(input int accum);
    return 2 * accum;
  endfunction

  function automatic int cbits(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/viscapture_if.sv
// Output stream bundle from the capture buffer toward the host bridge.
// Master drives valid/last/data, slave drives ready.
interface viscapture_if #(
  parameter int W = 12
) ();
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [W-1:0] m_tdata;

  modport master (
    output m_tvalid,
    output m_tlast,
    output m_tdata,
    input  m_tready
  );

  modport slave (
    input  m_tvalid,
    input  m_tlast,
    input  m_tdata,
    output m_tready
  );
endinterface

// File: rtl/visram_dp.sv
// Simple dual-port frame RAM: sync write, registered read.
// Bank is the address MSB; depth covers both ping-pong halves.
module visram_dp #(
  parameter int W     = 12,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/viscapture.sv
// Ping-pong frame capture and stream-out for the visibility chain.
// Define VISCAPTURE_HEADER_EN to prefix each frame with a sequence beat.
module viscapture
  import vis_pkg::*;
#(
  parameter int ACCUM = 6,
  parameter int COUNT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vis_frame_i,
  input  logic             vis_valid_i,
  input  logic             vis_first_i,
  input  logic             vis_last_i,
  input  logic [ACCUM-1:0] vis_real_i,
  input  logic [ACCUM-1:0] vis_imag_i,
  viscapture_if.master     m,
  output logic             overflow_o,
  output logic             framing_o,
  output logic [7:0]       dropped_o
);

  localparam int CBITS = cbits(COUNT);
  localparam int DBITS = dbits(ACCUM);
  localparam int FW    = CBITS + 1;
  localparam logic [CBITS-1:0] LASTIDX = CBITS'(COUNT - 1);
  localparam bit ONE = (COUNT == 1);

`ifdef VISCAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB = COUNT + HDR;

  // write side
  wstate_t          ws_q, ws_d;
  logic [CBITS-1:0] widx_q, widx_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             frm_q, frm_d;
  logic [7:0]       drop_q, drop_d;
  logic             we, complete, drop_ev, ferr;
  logic [CBITS-1:0] wa_idx;
  logic             wempty;

  // read side
  rstate_t          rs_q, rs_d;
  logic             rbank_q, rbank_d;
  logic [FW-1:0]    fidx_q, fidx_d;
  logic             rdv_q, rdv_d;
  logic             rdl_q, rdl_d;
  logic             rdh_q, rdh_d;
  logic             tv_q, tv_d;
  logic             tl_q, tl_d;
  logic [DBITS-1:0] td_q, td_d;
  logic             ren, out_load, out_fire, rd_free, more, active;
  logic [CBITS:0]   raddr;
  logic [DBITS-1:0] rdata;
  logic [DBITS-1:0] hword;

  assign out_fire = tv_q & m.m_tready;
  assign rd_free  = out_fire & tl_q;

  // a bank released by the reader this cycle is already free for a new frame
  assign wempty = !full_q[wbank_q] ||
                  (rd_free && (rbank_q == wbank_q));

  always_comb begin
    ws_d     = ws_q;
    widx_d   = widx_q;
    wbank_d  = wbank_q;
    ovf_d    = ovf_q;
    frm_d    = frm_q;
    we       = 1'b0;
    wa_idx   = widx_q;
    complete = 1'b0;
    drop_ev  = 1'b0;
    ferr     = 1'b0;
    unique case (ws_q)
      W_IDLE: begin
        if (vis_valid_i && vis_first_i) begin
          if (!wempty) begin
            ovf_d   = 1'b1;
            drop_ev = 1'b1;
            if (!vis_last_i) ws_d = W_DROP;
          end else if (vis_last_i) begin
            if (ONE) begin
              we       = 1'b1;
              wa_idx   = '0;
              complete = 1'b1;
            end else begin
              ferr = 1'b1;
            end
          end else if (ONE) begin
            ferr = 1'b1;
          end else begin
            we     = 1'b1;
            wa_idx = '0;
            widx_d = CBITS'(1);
            ws_d   = W_FILL;
          end
        end
      end
      W_FILL: begin
        if (!vis_frame_i) begin
          ferr = 1'b1;
        end else if (vis_valid_i) begin
          if (vis_first_i) begin
            ferr = 1'b1;
          end else if (widx_q == LASTIDX) begin
            if (vis_last_i) begin
              we       = 1'b1;
              complete = 1'b1;
              ws_d     = W_IDLE;
            end else begin
              ferr = 1'b1;
            end
          end else if (vis_last_i) begin
            ferr = 1'b1;
          end else begin
            we     = 1'b1;
            widx_d = widx_q + CBITS'(1);
          end
        end
      end
      W_DROP: begin
        if ((vis_valid_i && vis_last_i) || !vis_frame_i) begin
          ws_d = W_IDLE;
        end
      end
      default: ws_d = W_IDLE;
    endcase
    if (ferr) begin
      frm_d   = 1'b1;
      drop_ev = 1'b1;
      we      = 1'b0;
      ws_d    = W_IDLE;
    end
    if (complete) wbank_d = ~wbank_q;
  end

  always_comb begin
    full_d = full_q;
    if (complete) full_d[wbank_q] = 1'b1;
    if (rd_free)  full_d[rbank_q] = 1'b0;
  end

  assign drop_d = (drop_ev && drop_q != 8'hFF) ?
                  drop_q + 8'd1 : drop_q;

  always_comb begin
    rs_d    = rs_q;
    rbank_d = rbank_q;
    fidx_d  = fidx_q;
    rdv_d   = rdv_q;
    rdl_d   = rdl_q;
    rdh_d   = rdh_q;
    tv_d    = tv_q;
    tl_d    = tl_q;
    td_d    = td_q;
    more     = fidx_q < FW'(NB);
    active   = (rs_q == R_IDLE) ? full_q[rbank_q] : 1'b1;
    out_load = rdv_q && (!tv_q || m.m_tready);
    // RAM output register acts as the skid slot behind the output register
    ren      = active && more && (!rdv_q || out_load);
    unique case (rs_q)
      R_IDLE:   if (full_q[rbank_q]) rs_d = R_LOAD;
      R_LOAD:   rs_d = R_STREAM;
      R_STREAM: begin
        if (rd_free) begin
          rs_d    = R_IDLE;
          rbank_d = ~rbank_q;
        end
      end
      default:  rs_d = R_IDLE;
    endcase
    if (ren) begin
      fidx_d = fidx_q + FW'(1);
      rdv_d  = 1'b1;
      rdl_d  = (fidx_q == FW'(NB - 1));
      rdh_d  = (HDR != 0) && (fidx_q == '0);
    end else if (out_load) begin
      rdv_d = 1'b0;
    end
    if (rd_free) fidx_d = '0;
    if (out_load) begin
      tv_d = 1'b1;
      tl_d = rdl_q;
      td_d = rdh_q ? hword : rdata;
    end else if (out_fire) begin
      tv_d = 1'b0;
    end
  end

  assign raddr = {rbank_q, CBITS'(fidx_q - FW'(HDR))};

`ifdef VISCAPTURE_HEADER_EN
  logic [HDR_SEQ_W-1:0] seq_q;

  assign hword = DBITS'(32'(seq_q) << HDR_SEQ_LSB);

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q <= '0;
    end else if (rd_free) begin
      seq_q <= seq_q + 16'd1;
    end
  end
`else
  assign hword = '0;
`endif

  visram_dp #(
    .W     (DBITS),
    .AW    (CBITS + 1),
    .DEPTH (2 * COUNT)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i ({wbank_q, wa_idx}),
    .wdata_i ({vis_imag_i, vis_real_i}),
    .re_i    (ren),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ws_q    <= W_IDLE;
      widx_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
      ovf_q   <= 1'b0;
      frm_q   <= 1'b0;
      drop_q  <= '0;
      rs_q    <= R_IDLE;
      rbank_q <= 1'b0;
      fidx_q  <= '0;
      rdv_q   <= 1'b0;
      rdl_q   <= 1'b0;
      rdh_q   <= 1'b0;
      tv_q    <= 1'b0;
      tl_q    <= 1'b0;
      td_q    <= '0;
    end else begin
      ws_q    <= ws_d;
      widx_q  <= widx_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      frm_q   <= frm_d;
      drop_q  <= drop_d;
      rs_q    <= rs_d;
      rbank_q <= rbank_d;
      fidx_q  <= fidx_d;
      rdv_q   <= rdv_d;
      rdl_q   <= rdl_d;
      rdh_q   <= rdh_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
      td_q    <= td_d;
    end
  end

  assign m.m_tvalid = tv_q;
  assign m.m_tlast  = tl_q;
  assign m.m_tdata  = td_q;
  assign overflow_o = ovf_q;
  assign framing_o  = frm_q;
  assign dropped_o  = drop_q;

endmodule

// File: tb/tb_viscapture.sv
// Directed bench for viscapture: frame-pattern table plus
// hand-written latency, overflow and reset sequences.
module tb_viscapture;

  localparam int ACCUM = 6;
  localparam int COUNT = 16;
  localparam int DBITS = 2 * ACCUM;
`ifdef VISCAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  localparam int M_GOOD   = 0;
  localparam int M_SHORT  = 1;
  localparam int M_LONG   = 2;
  localparam int M_FALL   = 3;
  localparam int M_FIRST  = 4;
  localparam int M_SINGLE = 5;
  localparam int M_ORPHAN = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             vis_frame = 1'b0;
  logic             vis_valid = 1'b0;
  logic             vis_first = 1'b0;
  logic             vis_last = 1'b0;
  logic [ACCUM-1:0] vis_real = '0;
  logic [ACCUM-1:0] vis_imag = '0;
  logic             overflow_o;
  logic             framing_o;
  logic [7:0]       dropped_o;

  viscapture_if #(.W(DBITS)) axis ();

  viscapture #(
    .ACCUM (ACCUM),
    .COUNT (COUNT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .vis_frame_i (vis_frame),
    .vis_valid_i (vis_valid),
    .vis_first_i (vis_first),
    .vis_last_i  (vis_last),
    .vis_real_i  (vis_real),
    .vis_imag_i  (vis_imag),
    .m           (axis),
    .overflow_o  (overflow_o),
    .framing_o   (framing_o),
    .dropped_o   (dropped_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DBITS-1:0] d;
    logic             l;
  } beat_t;

  typedef struct {
    string name;
    int    mode;
    int    pos;
    int    rdy;
    bit    capt;
    int    framing;
    int    dropped;
  } vec_t;

  beat_t exp_q[$];
  beat_t act_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;
  int    exp_seq = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    vis_frame = 1'b0;
    vis_valid = 1'b0;
    vis_first = 1'b0;
    vis_last  = 1'b0;
    vis_real  = '0;
    vis_imag  = '0;
  endtask

  task automatic beat(input bit fr, input bit v, input bit f,
                      input bit l, input int k, input int b);
    vis_frame = fr;
    vis_valid = v;
    vis_first = f;
    vis_last  = l;
    vis_real  = ACCUM'(k + 16 * b);
    vis_imag  = ACCUM'(15 - k);
    tick();
  endtask

  task automatic expect_frame(input int b);
    beat_t e;
    if (HDR != 0) begin
      e.d = DBITS'(exp_seq & 16'hFFFF);
      e.l = 1'b0;
      exp_q.push_back(e);
    end
    exp_seq++;
    for (int k = 0; k < COUNT; k++) begin
      e.d = {ACCUM'(15 - k), ACCUM'(k + 16 * b)};
      e.l = (k == COUNT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int mode, input int pos, input int b);
    case (mode)
      M_GOOD:
        for (int k = 0; k < COUNT; k++)
          beat(1, 1, k == 0, k == COUNT - 1, k, b);
      M_SHORT:
        for (int k = 0; k <= pos; k++)
          beat(1, 1, k == 0, k == pos, k, b);
      M_LONG:
        for (int k = 0; k < COUNT + 2; k++)
          beat(1, 1, k == 0, k == COUNT + 1, k, b);
      M_FALL:
        for (int k = 0; k < pos; k++)
          beat(1, 1, k == 0, 0, k, b);
      M_FIRST:
        for (int k = 0; k < COUNT; k++)
          beat(1, 1, k == 0 || k == pos, k == COUNT - 1, k, b);
      M_SINGLE:
        beat(1, 1, 1, 1, 0, b);
      default:
        for (int k = 0; k < COUNT; k++)
          beat(0, 1, 0, k == COUNT - 1, k, b);
    endcase
    idle_in();
    tick();
  endtask

  task automatic wait_out(input string name, input int n);
    int cyc;
    cyc = 0;
    while (act_q.size() < n && cyc < 2000) begin
      tick();
      cyc++;
    end
    checks++;
    if (act_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats, expected %0d",
               name, act_q.size(), n);
    end
    repeat (30) tick();
  endtask

  task automatic compare(input string name);
    int n;
    check({name, "_beats"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", name, i),
            int'(act_q[i].d), int'(exp_q[i].d));
      check($sformatf("%s_last%0d", name, i),
            int'(act_q[i].l), int'(exp_q[i].l));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    act_q.delete();
    exp_q.delete();
    exp_seq = 0;
  endtask

  initial begin
    axis.m_tready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       axis.m_tready = 1'b1;
        1:       axis.m_tready = ~axis.m_tready;
        default: axis.m_tready = 1'b0;
      endcase
    end
  end

  // output monitor: collects handshaken beats, checks stability on stalls
  initial begin
    bit    hold_v;
    beat_t hold_b;
    beat_t a;
    hold_v = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", int'(axis.m_tvalid), 1);
          check("stall_data", int'(axis.m_tdata), int'(hold_b.d));
          check("stall_last", int'(axis.m_tlast), int'(hold_b.l));
        end
        a.d = axis.m_tdata;
        a.l = axis.m_tlast;
        if (axis.m_tvalid && axis.m_tready) begin
          act_q.push_back(a);
          hold_v = 1'b0;
        end else if (axis.m_tvalid) begin
          hold_v = 1'b1;
          hold_b = a;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   lat;
    int   cyc;

    vt[0] = '{"nominal",  M_GOOD,   0, 0, 1, 0, 0};
    vt[1] = '{"backpres", M_GOOD,   0, 1, 1, 0, 0};
    vt[2] = '{"short9",   M_SHORT,  9, 0, 0, 1, 1};
    vt[3] = '{"nolast",   M_LONG,   0, 0, 0, 1, 1};
    vt[4] = '{"fall7",    M_FALL,   7, 0, 0, 1, 1};
    vt[5] = '{"first5",   M_FIRST,  5, 0, 0, 1, 1};
    vt[6] = '{"single",   M_SINGLE, 0, 0, 0, 1, 1};
    vt[7] = '{"orphan",   M_ORPHAN, 0, 0, 0, 0, 0};

    do_reset();
    reset = 1'b1;
    tick();
    check("rst_tvalid", int'(axis.m_tvalid), 0);
    check("rst_tlast", int'(axis.m_tlast), 0);
    check("rst_tdata", int'(axis.m_tdata), 0);
    check("rst_overflow", int'(overflow_o), 0);
    check("rst_framing", int'(framing_o), 0);
    check("rst_dropped", int'(dropped_o), 0);

    foreach (vt[i]) begin
      do_reset();
      rdy_mode = vt[i].rdy;
      if (vt[i].capt) expect_frame(0);
      send(vt[i].mode, vt[i].pos, 0);
      expect_frame(1);
      send(M_GOOD, 0, 1);
      wait_out(vt[i].name, exp_q.size());
      compare(vt[i].name);
      check({vt[i].name, "_overflow"}, int'(overflow_o), 0);
      check({vt[i].name, "_framing"}, int'(framing_o), vt[i].framing);
      check({vt[i].name, "_dropped"}, int'(dropped_o), vt[i].dropped);
    end

    // latency from input last to first output valid
    do_reset();
    rdy_mode = 0;
    expect_frame(2);
    for (int k = 0; k < COUNT; k++)
      beat(1, 1, k == 0, k == COUNT - 1, k, 2);
    idle_in();
    lat = 0;
    while (!axis.m_tvalid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 2);
    wait_out("latency", exp_q.size());
    compare("latency");

    // overflow: two frames buffered, third dropped
    do_reset();
    rdy_mode = 2;
    expect_frame(0);
    send(M_GOOD, 0, 0);
    expect_frame(1);
    send(M_GOOD, 0, 1);
    send(M_GOOD, 0, 2);
    repeat (5) tick();
    check("ovf_flag", int'(overflow_o), 1);
    check("ovf_dropped", int'(dropped_o), 1);
    check("ovf_framing", int'(framing_o), 0);
    check("ovf_none_out", act_q.size(), 0);
    rdy_mode = 0;
    wait_out("overflow", exp_q.size());
    compare("overflow");

    // reset in the middle of a readout
    do_reset();
    rdy_mode = 0;
    send(M_SHORT, 9, 0);
    check("mid_framing_pre", int'(framing_o), 1);
    check("mid_dropped_pre", int'(dropped_o), 1);
    send(M_GOOD, 0, 2);
    cyc = 0;
    while (act_q.size() < 5 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("mid_reached_beat5", int'(act_q.size() >= 5), 1);
    reset = 1'b1;
    tick();
    check("mid_tvalid", int'(axis.m_tvalid), 0);
    check("mid_framing", int'(framing_o), 0);
    check("mid_overflow", int'(overflow_o), 0);
    check("mid_dropped", int'(dropped_o), 0);
    reset = 1'b0;
    tick();
    check("mid_tvalid_after", int'(axis.m_tvalid), 0);
    act_q.delete();
    exp_q.delete();
    exp_seq = 0;
    expect_frame(3);
    send(M_GOOD, 0, 3);
    wait_out("after_reset", exp_q.size());
    compare("after_reset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
